// File: rtl/apb_pkg.sv
// Shared APB constants and the master sequencer state encoding.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the pointer,
// and advances the pointer past the winner when en is asserted.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_reg;
  int               cand;

  // Walk from the farthest candidate back to the pointer so the nearest wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        grant_idx = IDX_W'(cand);
        grant_any = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = grant_any && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (en) begin
      ptr_reg <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin shared APB master: arbitrates requesters and sequences IDLE/SETUP/ACCESS.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT cycles.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_W-1:0]          paddr,
  output logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  input  logic                       pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end
  endgenerate

  apb_state_t state_reg, state_next;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               arb_en;
  logic               done;
  logic               abort;

  logic [IDX_W-1:0]   id_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic               write_reg;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr[NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             wait_expired;

  // The stall that would bring the count to TIMEOUT ends the transfer.
  assign wait_expired = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || state_next == SETUP) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ACCESS && !pready) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`else
  logic wait_expired;
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    arb_en     = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_any && !reset) begin
          arb_en     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (wait_expired) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = arb_en ? grant : '0;
  assign psel      = (state_reg != IDLE);
  assign penable   = (state_reg == ACCESS);
  assign paddr     = addr_reg;
  assign pwdata    = wdata_reg;
  assign pwrite    = write_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rsp_valid <= done || abort;
      if (arb_en) begin
        id_reg    <= grant_idx;
        addr_reg  <= addr_arr[grant_idx];
        wdata_reg <= wdata_arr[grant_idx];
        write_reg <= req_write[grant_idx];
      end
      if (done) begin
        rsp_id    <= id_reg;
        rsp_err   <= pslverr;
        rsp_rdata <= write_reg ? '0 : prdata;
      end else if (abort) begin
        rsp_id    <= id_reg;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter (NUM_REQ=2, 8-bit bus).
module tb_apb_master_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_id;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr, pwdata, prdata;
  logic        pready, pslverr;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  apb_master_arbiter #(
    .NUM_REQ (2),
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    req_write[i]       = w;
    req_addr[i*8 +: 8]  = a;
    req_wdata[i*8 +: 8] = d;
  endtask

  int cnt0, cnt1, exp_id;

  initial begin
    reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", paddr, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    req_valid = 2'b01; #1;
    check("rst_req_ready", req_ready, 0);
    req_valid = 2'b00;
    reset = 1'b0;
    tick();
    $display("[TB] reset state checked");

    // Single write, zero wait states
    pready = 1'b1;
    set_req(0, 1'b1, 8'h10, 8'hA5); req_valid = 2'b01; #1;
    check("wr_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_paddr", paddr, 8'h10);
    check("wr_setup_pwrite", pwrite, 1);
    check("wr_setup_pwdata", pwdata, 8'hA5);
    tick();
    check("wr_access_penable", penable, 1);
    check("wr_access_psel", psel, 1);
    check("wr_access_pwdata", pwdata, 8'hA5);
    check("wr_access_rsp_valid", rsp_valid, 0);
    tick();
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_id", rsp_id, 0);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_done_psel", psel, 0);
    tick();
    check("wr_rsp_pulse", rsp_valid, 0);
    $display("[TB] write req0 addr=10 wdata=a5 id=%0d err=%0d", rsp_id, rsp_err);

    // Read with two wait states
    pready = 1'b0; prdata = 8'h3C;
    set_req(1, 1'b0, 8'h20, 8'h00); req_valid = 2'b10; #1;
    check("rd_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    check("rd_setup_paddr", paddr, 8'h20);
    check("rd_setup_pwrite", pwrite, 0);
    tick();
    check("rd_wait1_penable", penable, 1);
    check("rd_wait1_paddr", paddr, 8'h20);
    tick();
    check("rd_wait2_penable", penable, 1);
    check("rd_wait2_paddr", paddr, 8'h20);
    check("rd_wait2_rsp_valid", rsp_valid, 0);
    pready = 1'b1;
    tick();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 8'h3C);
    check("rd_rsp_id", rsp_id, 1);
    $display("[TB] read req1 addr=20 rdata=%0h id=%0d", rsp_rdata, rsp_id);

    // Both requesters continuously valid: grants must alternate
    set_req(0, 1'b0, 8'h30, 8'h00);
    set_req(1, 1'b0, 8'h31, 8'h00);
    cnt0 = 4; cnt1 = 4;
    for (int i = 0; i < 8; i++) begin
      exp_id = i % 2;
      req_valid = {cnt1 > 0, cnt0 > 0};
      prdata = 8'h40 + 8'(i);
      #1;
      check("rr_ready", req_ready, (exp_id == 0) ? 2'b01 : 2'b10);
      tick();
      if (exp_id == 0) cnt0--; else cnt1--;
      req_valid = {cnt1 > 0, cnt0 > 0};
      check("rr_paddr", paddr, (exp_id == 0) ? 8'h30 : 8'h31);
      tick(); tick();
      check("rr_rsp_valid", rsp_valid, 1);
      check("rr_rsp_id", rsp_id, exp_id);
      check("rr_rsp_rdata", rsp_rdata, 8'h40 + i);
      $display("[TB] rr txn %0d id=%0d rdata=%0h", i, rsp_id, rsp_rdata);
    end
    req_valid = 2'b00;

    // Slave error on a write, then a clean transfer
    pslverr = 1'b1; prdata = 8'h99;
    set_req(0, 1'b1, 8'hFF, 8'h5A); req_valid = 2'b01; #1;
    check("err_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    check("err_paddr", paddr, 8'hFF);
    check("err_pwdata", pwdata, 8'h5A);
    tick(); tick();
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_rdata", rsp_rdata, 0);
    $display("[TB] write req0 addr=ff err=%0d rdata=%0h", rsp_err, rsp_rdata);
    pslverr = 1'b0; prdata = 8'h77;
    set_req(1, 1'b0, 8'h21, 8'h00); req_valid = 2'b10; #1;
    check("ok_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    tick(); tick();
    check("ok_rsp_valid", rsp_valid, 1);
    check("ok_rsp_err", rsp_err, 0);
    check("ok_rsp_rdata", rsp_rdata, 8'h77);
    tick();
    check("hold_rsp_valid", rsp_valid, 0);
    check("hold_rsp_rdata", rsp_rdata, 8'h77);
    check("hold_rsp_id", rsp_id, 1);
    $display("[TB] read req1 addr=21 err=%0d rdata=%0h", rsp_err, rsp_rdata);

    // Reset in the middle of ACCESS
    pready = 1'b0;
    set_req(0, 1'b0, 8'h44, 8'h00); req_valid = 2'b01; #1;
    check("mr_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    tick();
    check("mr_access", penable, 1);
    reset = 1'b1;
    tick();
    check("mr_psel", psel, 0);
    check("mr_penable", penable, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    pready = 1'b1;
    tick();
    check("mr_rsp_valid2", rsp_valid, 0);
    reset = 1'b0;
    req_valid = 2'b11; #1;
    check("mr_ptr_zero", req_ready, 2'b01);
    tick(); req_valid = 2'b10;
    tick(); tick();
    check("mr_rsp0_valid", rsp_valid, 1);
    check("mr_rsp0_id", rsp_id, 0);
    #1;
    check("mr_req1_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    tick(); tick();
    check("mr_rsp1_valid", rsp_valid, 1);
    check("mr_rsp1_id", rsp_id, 1);
    $display("[TB] mid-transfer reset recovered, last id=%0d", rsp_id);

`ifdef APB_TIMEOUT_EN
    // Stalled slave: abort after 16 ACCESS cycles
    pready = 1'b0;
    set_req(0, 1'b0, 8'h55, 8'h00); req_valid = 2'b01; #1;
    check("to_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    tick();
    for (int k = 2; k <= 16; k++) begin
      tick();
      check("to_waiting", {penable, rsp_valid}, 2'b10);
    end
    tick();
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel", psel, 0);
    pready = 1'b1;
    $display("[TB] timeout abort err=%0d", rsp_err);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
